prep_byte_packer: RTL and testbench
===================================

Name: prep_byte_packer

Overview:
- Downstream stage of the PREP1 data path: consumes the 8-bit shift-register output Q, one byte per accepted cycle.
- Packs four consecutive bytes into a 32-bit word, little-endian.
- Buffers packed words in a small FIFO and presents them on a valid/ready output port to the next stage or bus bridge.
- Supports a flush request that emits a partial word zero-padded.

Parameters:
- AW, 2: FIFO address width; DEPTH = 2**AW words.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data valid this cycle.
- in_data  input  8  byte from PREP1 Q.
- in_ready  output  1  block accepts in_data this cycle.
- flush  input  1  request to push the partial word, zero-padded.
- flush_done  output  1  one-cycle pulse when a flush completes.
- out_valid  output  1  FIFO head word available.
- out_data  output  32  FIFO head word; 0 when empty.
- out_ready  input  1  consumer takes the head word this cycle.
- level  output  AW+1  number of words in the FIFO.
- byte_cnt  output  2  bytes held in the assembly register (0..3).

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset state:
  - byte_cnt=0, assembly register=0, FIFO empty, level=0.
  - out_valid=0, out_data=0, flush_done=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation: discards all partial and buffered data.
- Accept rule: a byte is accepted when in_valid && in_ready.
  - The byte is written to lane byte_cnt, bits [8*byte_cnt+7 : 8*byte_cnt].
  - byte_cnt then increments, wrapping 3→0.
- in_ready = (byte_cnt != 3) || (level < DEPTH).
  - Registered-state only; no combinational path from out_ready.
- Push on completion: when the 4th byte is accepted, the completed word, including that byte, is written to the FIFO tail at the same edge.
  - The assembly register clears to 0 and byte_cnt becomes 0.
  - Latency: the word appears on out_data with out_valid=1 in the cycle after the 4th byte is accepted.
- Pop: occurs when out_valid && out_ready; the head advances at the edge.
- Simultaneous push and pop:
  - Allowed at any level; level is unchanged.
  - At level=DEPTH, a pop in the same cycle does NOT enable a push, because in_ready is already 0.
- Full: while level=DEPTH and byte_cnt=3, in_ready=0.
  - Bytes 0..2 of the next word are still accepted while the FIFO is full.
- Empty: out_valid=0 and out_data=0. A pop attempt is ignored and level stays 0.
- Flush is a level request, executed in the first cycle where byte_cnt_eff != 0 and level < DEPTH (or level=DEPTH with a same-cycle pop not counted).
  - byte_cnt_eff is byte_cnt after any same-cycle accepted byte.
  - Execution pushes the assembly word with unfilled upper lanes = 0, clears byte_cnt, and pulses flush_done.
  - If byte_cnt_eff == 0, flush completes immediately: flush_done pulses, nothing is pushed.
  - If flush and an accepted 4th byte coincide, only the normal push occurs and flush_done pulses.
  - flush_done pulses once per rising edge of flush. Flush must be held until flush_done; a deasserted flush before completion is dropped.
- level range: 0..DEPTH. FIFO pointers wrap modulo DEPTH, with an extra wrap bit for full/empty detection.

Optional Feature:
- Macro: PREP_PACK_CHKSUM_EN.
- Defined:
  - Adds output out_chk, 8 bits, stored per FIFO entry alongside its word.
  - out_chk = XOR of the four byte lanes of that entry; zero-padded lanes contribute 0.
  - out_chk follows out_data (0 when empty, reset 0).
- Undefined: out_chk port and checksum storage are absent; all other behaviour is identical.

Test Plan:
- Reset, then drive bytes 0x11,0x22,0x33,0x44 with out_ready=0:
  - out_valid=1 next cycle, out_data=0x44332211, level=1, byte_cnt=0.
  - Checksum build: out_chk=0x44.
- Stream 4*DEPTH+3 bytes with out_ready=0:
  - level=4, byte_cnt=3, in_ready=0.
  - Raise out_ready for one cycle: level=3, in_ready=1. The next byte then pushes, giving level=4.
- Accept 0xAA,0xBB, then assert flush:
  - flush_done pulses once.
  - Pushed word = 0x0000BBAA, byte_cnt=0.
  - Assert flush with byte_cnt=0: flush_done pulses and level is unchanged.
- Continuous in_valid=1 and out_ready=1 for 64 bytes:
  - One word per 4 cycles; level never exceeds 1; word order and content match the input order.
- Assert RST mid-word (byte_cnt=2) with level=2:
  - Next cycle: level=0, out_valid=0, out_data=0, byte_cnt=0, in_ready=1.
- Same-edge 4th byte with flush=1:
  - Exactly one word pushed, flush_done=1, and no extra zero word appears.

Source files
------------

// File: rtl/prep_byte_packer_if.sv
// Byte-in / word-out handshake bundle for prep_byte_packer.
// PREP_PACK_CHKSUM_EN adds the per-word checksum signal out_chk.
interface prep_byte_packer_if #(
  parameter int unsigned AW = 2
);
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        flush_done;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [AW:0] level;
  logic [1:0]  byte_cnt;
`ifdef PREP_PACK_CHKSUM_EN
  logic [7:0]  out_chk;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, flush_done, out_valid, out_data, level, byte_cnt, out_chk
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, flush_done, out_valid, out_data, level, byte_cnt, out_chk
  );
`else
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, flush_done, out_valid, out_data, level, byte_cnt
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, flush_done, out_valid, out_data, level, byte_cnt
  );
`endif
endinterface

// File: rtl/prep_byte_packer.sv
// Packs PREP1 bytes little-endian into 32-bit words and buffers them in a 2**AW FIFO.
// Optional macro PREP_PACK_CHKSUM_EN stores an XOR checksum per word (out_chk).
module prep_byte_packer #(
  parameter int unsigned AW = 2
) (
  input logic               CLK,
  input logic               RST,
  prep_byte_packer_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {StIdle, StDone, StHold} flush_st_e;

  flush_st_e   state_q, state_d;
  logic [1:0]  cnt_q, cnt_d, cnt_eff;
  logic [31:0] asm_q, asm_d, asm_eff;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [31:0] mem_data [DEPTH];
  logic        full, empty, in_ready, accept, pop, push;
  logic        word_done, flush_exec, flush_push, flush_done;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = (cnt_q != 2'd3) || !full;
  assign accept   = bus.in_valid && in_ready;
  assign pop      = !empty && bus.out_ready;

  // Assembly view after any byte accepted this cycle.
  always_comb begin
    asm_eff = asm_q;
    cnt_eff = cnt_q;
    if (accept) begin
      asm_eff[8*cnt_q +: 8] = bus.in_data;
      cnt_eff               = cnt_q + 2'd1;
    end
  end

  assign word_done  = accept && (cnt_q == 2'd3);
  assign flush_push = flush_exec && (cnt_eff != 2'd0);
  assign push       = word_done || flush_push;
  assign cnt_d      = flush_push ? 2'd0 : cnt_eff;
  assign asm_d      = push ? 32'd0 : asm_eff;

  // Flush FSM: state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Flush FSM: next state. StHold waits for flush to drop so one request gives one pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (flush_exec) state_d = StDone;
      StDone:  state_d = bus.flush ? StHold : StIdle;
      StHold:  if (!bus.flush) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Flush FSM: outputs. A full FIFO blocks a flush push even if a pop happens this cycle.
  always_comb begin
    flush_exec = (state_q == StIdle) && bus.flush && ((cnt_eff == 2'd0) || !full);
    flush_done = (state_q == StDone);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= 2'd0;
      asm_q    <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_data[wr_ptr_q[AW-1:0]] <= asm_eff;
  end

  assign bus.in_ready   = in_ready;
  assign bus.flush_done = flush_done;
  assign bus.out_valid  = !empty;
  assign bus.out_data   = empty ? 32'd0 : mem_data[rd_ptr_q[AW-1:0]];
  assign bus.level      = wr_ptr_q - rd_ptr_q;
  assign bus.byte_cnt   = cnt_q;

`ifdef PREP_PACK_CHKSUM_EN
  logic [7:0] mem_chk [DEPTH];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_chk[wr_ptr_q[AW-1:0]] <= asm_eff[7:0] ^ asm_eff[15:8] ^ asm_eff[23:16] ^ asm_eff[31:24];
    end
  end

  assign bus.out_chk = empty ? 8'd0 : mem_chk[rd_ptr_q[AW-1:0]];
`endif
endmodule

// File: tb/tb_prep_byte_packer.sv
// Randomized and directed bench for prep_byte_packer against a queue-based reference model.
module tb_prep_byte_packer;
  localparam int unsigned AW    = 2;
  localparam int          DEPTH = 2 ** AW;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  prep_byte_packer_if #(.AW(AW)) bus ();

  prep_byte_packer #(.AW(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: pending bytes and buffered words as queues.
  logic [7:0]  m_bytes [$];
  logic [31:0] m_fifo  [$];
  bit          m_served;
  bit          m_done;

  function automatic logic [31:0] pack(input logic [7:0] q [$]);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < q.size(); i++) w = w | (32'(q[i]) << (8 * i));
    return w;
  endfunction

  function automatic logic [7:0] chk_of(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    m_bytes.delete(); m_fifo.delete(); m_served = 0; m_done = 0;
  endtask

  // One clock: drive inputs, advance the model, return #1 after the edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit f);
    bit rdy, acc, pp, nd;
    int lvl_before;
    bus.in_valid = v; bus.in_data = d; bus.out_ready = r; bus.flush = f;
    lvl_before = m_fifo.size();
    rdy = (m_bytes.size() != 3) || (lvl_before < DEPTH);
    acc = v && rdy;
    pp  = r && (lvl_before > 0);
    @(posedge CLK);
    if (pp) void'(m_fifo.pop_front());
    if (acc) m_bytes.push_back(d);
    if (m_bytes.size() == 4) begin
      m_fifo.push_back(pack(m_bytes));
      m_bytes.delete();
    end
    nd = 0;
    if (f && !m_served) begin
      if (m_bytes.size() == 0) nd = 1;
      else if (lvl_before < DEPTH) begin
        m_fifo.push_back(pack(m_bytes));
        m_bytes.delete();
        nd = 1;
      end
    end
    m_served = f ? (m_served || nd) : 0;
    m_done   = nd;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
    if (bus.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h exp 0", bus.out_data); end
    if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", bus.level); end
    if (bus.byte_cnt !== 2'd0) begin errors++; $display("FAIL reset_byte_cnt: got %0d exp 0", bus.byte_cnt); end
    if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b exp 0", bus.flush_done); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, b[i], 1'b0, 1'b0);
    checks += 4;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b exp 1", bus.out_valid); end
    if (bus.out_data !== 32'h44332211) begin errors++; $display("FAIL basic_out_data: got %h exp 44332211", bus.out_data); end
    if (bus.level !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d exp 1", bus.level); end
    if (bus.byte_cnt !== 2'd0) begin errors++; $display("FAIL basic_byte_cnt: got %0d exp 0", bus.byte_cnt); end
`ifdef PREP_PACK_CHKSUM_EN
    checks++;
    if (bus.out_chk !== 8'h44) begin errors++; $display("FAIL basic_out_chk: got %h exp 44", bus.out_chk); end
`endif
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4 * DEPTH + 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    checks += 3;
    if (bus.level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d exp 4", bus.level); end
    if (bus.byte_cnt !== 2'd3) begin errors++; $display("FAIL full_byte_cnt: got %0d exp 3", bus.byte_cnt); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b exp 0", bus.in_ready); end
    // A byte offered together with the pop must still be refused.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    checks += 3;
    if (bus.level !== 3'd3) begin errors++; $display("FAIL full_pop_level: got %0d exp 3", bus.level); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_in_ready: got %b exp 1", bus.in_ready); end
    if (bus.byte_cnt !== 2'd3) begin errors++; $display("FAIL full_pop_byte_cnt: got %0d exp 3", bus.byte_cnt); end
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    checks += 2;
    if (bus.level !== 3'd4) begin errors++; $display("FAIL full_refill_level: got %0d exp 4", bus.level); end
    if (bus.byte_cnt !== 2'd0) begin errors++; $display("FAIL full_refill_byte_cnt: got %0d exp 0", bus.byte_cnt); end
    while (m_fifo.size() > 0) begin
      checks++;
      if (bus.out_data !== m_fifo[0]) begin errors++; $display("FAIL full_drain_data: got %h exp %h", bus.out_data, m_fifo[0]); end
      cycle(1'b0, 8'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush();
    int pulses = 0;
    do_reset();
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0);
    for (int i = 0; i < 8 && pulses == 0; i++) begin
      cycle(1'b0, 8'd0, 1'b0, 1'b1);
      if (bus.flush_done === 1'b1) pulses++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'd0, 1'b0, 1'b0);
      if (bus.flush_done === 1'b1) pulses++;
    end
    checks += 4;
    if (pulses != 1) begin errors++; $display("FAIL flush_pulses: got %0d exp 1", pulses); end
    if (bus.out_data !== 32'h0000BBAA) begin errors++; $display("FAIL flush_word: got %h exp 0000bbaa", bus.out_data); end
    if (bus.byte_cnt !== 2'd0) begin errors++; $display("FAIL flush_byte_cnt: got %0d exp 0", bus.byte_cnt); end
    if (bus.level !== 3'd1) begin errors++; $display("FAIL flush_level: got %0d exp 1", bus.level); end
`ifdef PREP_PACK_CHKSUM_EN
    checks++;
    if (bus.out_chk !== 8'h11) begin errors++; $display("FAIL flush_out_chk: got %h exp 11", bus.out_chk); end
`endif
    pulses = 0;
    for (int i = 0; i < 8 && pulses == 0; i++) begin
      cycle(1'b0, 8'd0, 1'b0, 1'b1);
      if (bus.flush_done === 1'b1) pulses++;
    end
    cycle(1'b0, 8'd0, 1'b0, 1'b0);
    checks += 2;
    if (pulses != 1) begin errors++; $display("FAIL flush_empty_pulse: got %0d exp 1", pulses); end
    if (bus.level !== 3'd1) begin errors++; $display("FAIL flush_empty_level: got %0d exp 1", bus.level); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  sent [64];
    logic [31:0] got  [$];
    int          max_lvl = 0;
    do_reset();
    for (int i = 0; i < 66; i++) begin
      if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
      if (i < 64) begin
        sent[i] = 8'($urandom);
        cycle(1'b1, sent[i], 1'b1, 1'b0);
      end else cycle(1'b0, 8'd0, 1'b1, 1'b0);
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
    end
    checks += 2;
    if (max_lvl > 1) begin errors++; $display("FAIL b2b_max_level: got %0d exp <=1", max_lvl); end
    if (got.size() != 16) begin errors++; $display("FAIL b2b_word_count: got %0d exp 16", got.size()); end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      logic [31:0] exp_w;
      exp_w = {sent[4*k+3], sent[4*k+2], sent[4*k+1], sent[4*k]};
      checks++;
      if (got[k] !== exp_w) begin errors++; $display("FAIL b2b_word%0d: got %h exp %h", k, got[k], exp_w); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    checks += 2;
    if (bus.level !== 3'd2) begin errors++; $display("FAIL rmid_pre_level: got %0d exp 2", bus.level); end
    if (bus.byte_cnt !== 2'd2) begin errors++; $display("FAIL rmid_pre_byte_cnt: got %0d exp 2", bus.byte_cnt); end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    m_bytes.delete(); m_fifo.delete(); m_served = 0; m_done = 0;
    checks += 5;
    if (bus.level !== 3'd0) begin errors++; $display("FAIL rmid_level: got %0d exp 0", bus.level); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b exp 0", bus.out_valid); end
    if (bus.out_data !== 32'd0) begin errors++; $display("FAIL rmid_out_data: got %h exp 0", bus.out_data); end
    if (bus.byte_cnt !== 2'd0) begin errors++; $display("FAIL rmid_byte_cnt: got %0d exp 0", bus.byte_cnt); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_flush_coincide();
    do_reset();
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    cycle(1'b1, 8'h03, 1'b0, 1'b0);
    cycle(1'b1, 8'hDD, 1'b0, 1'b1);
    checks += 4;
    if (bus.level !== 3'd1) begin errors++; $display("FAIL coin_level: got %0d exp 1", bus.level); end
    if (bus.flush_done !== 1'b1) begin errors++; $display("FAIL coin_flush_done: got %b exp 1", bus.flush_done); end
    if (bus.byte_cnt !== 2'd0) begin errors++; $display("FAIL coin_byte_cnt: got %0d exp 0", bus.byte_cnt); end
    if (bus.out_data !== 32'hDD030201) begin errors++; $display("FAIL coin_word: got %h exp dd030201", bus.out_data); end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0);
    checks += 2;
    if (bus.level !== 3'd1) begin errors++; $display("FAIL coin_no_extra: got %0d exp 1", bus.level); end
    if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL coin_done_once: got %b exp 0", bus.flush_done); end
  endtask

  task automatic test_random();
    bit f = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (!f) f = ($urandom_range(0, 9) == 0);
      else if (m_done) f = 0;
      else if ($urandom_range(0, 19) == 0) f = 0;
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0), f);
      checks += 6;
      if (bus.out_valid !== (m_fifo.size() > 0)) begin
        errors++; $display("FAIL rnd_out_valid @%0d: got %b exp %b", i, bus.out_valid, m_fifo.size() > 0);
      end
      if (bus.out_data !== ((m_fifo.size() > 0) ? m_fifo[0] : 32'd0)) begin
        errors++; $display("FAIL rnd_out_data @%0d: got %h", i, bus.out_data);
      end
      if (int'(bus.level) !== m_fifo.size()) begin
        errors++; $display("FAIL rnd_level @%0d: got %0d exp %0d", i, bus.level, m_fifo.size());
      end
      if (int'(bus.byte_cnt) !== m_bytes.size()) begin
        errors++; $display("FAIL rnd_byte_cnt @%0d: got %0d exp %0d", i, bus.byte_cnt, m_bytes.size());
      end
      if (bus.flush_done !== m_done) begin
        errors++; $display("FAIL rnd_flush_done @%0d: got %b exp %b", i, bus.flush_done, m_done);
      end
      if (bus.in_ready !== ((m_bytes.size() != 3) || (m_fifo.size() < DEPTH))) begin
        errors++; $display("FAIL rnd_in_ready @%0d: got %b", i, bus.in_ready);
      end
`ifdef PREP_PACK_CHKSUM_EN
      checks++;
      if (bus.out_chk !== ((m_fifo.size() > 0) ? chk_of(m_fifo[0]) : 8'd0)) begin
        errors++; $display("FAIL rnd_out_chk @%0d: got %h", i, bus.out_chk);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_flush_coincide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a test loop never returns.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end
endmodule
